// File: rtl/gp_bus_pkg.sv
// GP bus definitions shared by the write sequencer and the round-robin arbiter.
// Covers the address split (page/offset), the page map and the sequencer states.
package gp_bus_pkg;

    localparam int WTH_ADDR = 32;
    localparam int WTH_ADDL = 10;

    localparam int PAGE_GLOBAL  = 0;
    localparam int PAGE_CAPTURE = 1;
    localparam int PAGE_LASER   = 2;
    localparam int PAGE_BUS     = 3;
    localparam int PAGE_OTHER   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_GAP
    } gp_wr_state_t;

endpackage

// File: rtl/gp_rr_arbiter.sv
// Round-robin pick: first set req at or after start, wrapping modulo NREQ.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when a pick is consumed and moves start.
module gp_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  start,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            vld
);

    always_comb begin
        gnt = '0;
        idx = '0;
        vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int pos;
            pos = (int'(start) + k) % NREQ;
            if (!vld && req[pos]) begin
                vld      = 1'b1;
                idx      = pos[IDW-1:0];
                gnt[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gp_wr_arbiter.sv
// GP write arbiter: round-robin over NREQ requesters, latch winner, SETUP cycle then one-cycle wren+ack.
// Latency: wren/ack two cycles after req is seen in IDLE; one write per 3+GAP cycles.
// Backpressure: req held until ack; with GP_WR_ARB_PAGE_CHECK_EN pages above OTHER are dropped (ack+err_page).
module gp_wr_arbiter #(
    parameter int NREQ     = 4,
    parameter int WTH_ADDR = gp_bus_pkg::WTH_ADDR,
    parameter int WTH_DATA = 32,
    parameter int GAP      = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WTH_ADDR-1:0] req_addr,
    input  logic [NREQ*WTH_DATA-1:0] req_data,
    output logic [NREQ-1:0]          ack,
    output logic [WTH_ADDR-1:0]      bus_addr,
    output logic [WTH_DATA-1:0]      bus_wdata,
    output logic                     bus_wren,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     err_page
);
    import gp_bus_pkg::*;

    localparam int IDW = $clog2(NREQ);

    gp_wr_state_t        state_q, state_nxt;
    logic [WTH_ADDR-1:0] addr_q, addr_nxt;
    logic [WTH_DATA-1:0] data_q, data_nxt;
    logic [IDW-1:0]      gid_q, gid_nxt;
    logic [IDW-1:0]      ptr_q, ptr_nxt;
    logic [2:0]          cnt_q, cnt_nxt;
    logic [NREQ-1:0]     ack_q, ack_nxt;
    logic                wren_q, wren_nxt;
    logic                err_q, err_nxt;
    logic                busy_q;

    logic [NREQ-1:0]     req_eff;
    logic [NREQ-1:0]     pick_gnt;
    logic [IDW-1:0]      pick_idx;
    logic                pick_vld;
    logic [WTH_ADDR-1:0] sel_addr;
    logic [WTH_DATA-1:0] sel_data;
    logic                page_bad;

    // A requester sees its ack and drops req a cycle later; mask it so an ack
    // landing in IDLE (drop path with GAP=0) cannot re-grant the same write.
    assign req_eff = req & ~ack_q;

    gp_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req   (req_eff),
        .start (ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .vld   (pick_vld)
    );

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_addr = req_addr[i*WTH_ADDR +: WTH_ADDR];
                sel_data = req_data[i*WTH_DATA +: WTH_DATA];
            end
        end
    end

`ifdef GP_WR_ARB_PAGE_CHECK_EN
    localparam int WTH_PAGE = WTH_ADDR - WTH_ADDL;
    assign page_bad = sel_addr[WTH_ADDR-1:WTH_ADDL] > WTH_PAGE'(PAGE_OTHER);
`else
    assign page_bad = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        gid_nxt   = gid_q;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        ack_nxt   = '0;
        wren_nxt  = 1'b0;
        err_nxt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gid_nxt = pick_idx;
                    ptr_nxt = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
                    if (page_bad) begin
                        // Illegal page never reaches the bus: address/data keep their last value.
                        ack_nxt = pick_gnt;
                        err_nxt = 1'b1;
                        if (GAP > 0) begin
                            state_nxt = ST_GAP;
                            cnt_nxt   = '0;
                        end
                    end else begin
                        addr_nxt  = sel_addr;
                        data_nxt  = sel_data;
                        state_nxt = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                wren_nxt       = 1'b1;
                ack_nxt[gid_q] = 1'b1;
                state_nxt      = ST_STROBE;
            end
            ST_STROBE: begin
                if (GAP > 0) begin
                    state_nxt = ST_GAP;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == 3'(GAP - 1)) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + 3'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ack_q   <= '0;
            wren_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_nxt;
            data_q  <= data_nxt;
            gid_q   <= gid_nxt;
            ptr_q   <= ptr_nxt;
            cnt_q   <= cnt_nxt;
            ack_q   <= ack_nxt;
            wren_q  <= wren_nxt;
            err_q   <= err_nxt;
            busy_q  <= (state_nxt != ST_IDLE);
        end
    end

    assign ack       = ack_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = data_q;
    assign bus_wren  = wren_q;
    assign busy      = busy_q;
    assign grant_id  = gid_q;
    assign err_page  = err_q;

endmodule

// File: tb/tb_gp_wr_arbiter.sv
// Bench for gp_wr_arbiter: grant-order vectors plus hand sequences, scoreboarded at negedge.
module tb_gp_wr_arbiter;

    localparam int NREQ = 4;
    localparam int WA   = 32;
    localparam int WD   = 32;
    localparam int GAP  = 1;
    localparam int IDW  = $clog2(NREQ);
    localparam int NVEC = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*WA-1:0] req_addr;
    logic [NREQ*WD-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic [WA-1:0]      bus_addr;
    logic [WD-1:0]      bus_wdata;
    logic               bus_wren;
    logic               busy;
    logic [IDW-1:0]     grant_id;
    logic               err_page;

    always #5 clk = ~clk;

    gp_wr_arbiter #(
        .NREQ     (NREQ),
        .WTH_ADDR (WA),
        .WTH_DATA (WD),
        .GAP      (GAP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .ack       (ack),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wren  (bus_wren),
        .busy      (busy),
        .grant_id  (grant_id),
        .err_page  (err_page)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           drop;
        logic [WA-1:0]  addr;
        logic [WD-1:0]  data;
    } exp_t;

    typedef struct packed {
        logic [NREQ-1:0]          mask;
        logic [2:0]               n;
        logic [NREQ-1:0][IDW-1:0] order;
    } vec_t;

    exp_t sb[$];
    int   stamps[$];
    int   hold_cnt[NREQ];
    int   cyc;
    int   total;
    int   bad;
    vec_t vecs[NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk_vec(input logic [NREQ-1:0] mask, input int n,
                                    input int o0, input int o1, input int o2, input int o3);
        vec_t v;
        v.mask     = mask;
        v.n        = 3'(n);
        v.order[0] = IDW'(o0);
        v.order[1] = IDW'(o1);
        v.order[2] = IDW'(o2);
        v.order[3] = IDW'(o3);
        return v;
    endfunction

    function automatic logic [WA-1:0] mk_addr(input int i, input int v);
        return WA'((i % 4) << 10) | WA'(v * 16 + i);
    endfunction

    function automatic logic [WD-1:0] mk_data(input int i, input int v);
        return 32'hA5A5_0000 | WD'(v << 8) | WD'(i);
    endfunction

    task automatic set_req(input int i, input logic [WA-1:0] a, input logic [WD-1:0] d);
        req_addr[i*WA +: WA] = a;
        req_data[i*WD +: WD] = d;
    endtask

    task automatic push(input int id, input logic [WA-1:0] a, input logic [WD-1:0] d, input logic drop);
        exp_t e;
        e.id   = IDW'(id);
        e.drop = drop;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // One cycle: advance to negedge, score any bus transaction, then model requesters dropping req on ack.
    task automatic step();
        exp_t            e;
        logic [NREQ-1:0] oh;
        @(negedge clk);
        cyc++;
        if (bus_wren || ack != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_txn", {bus_wren, ack}, 0);
            end else begin
                e = sb.pop_front();
                oh = '0;
                oh[e.id] = 1'b1;
                chk("sb_ack", ack, oh);
                chk("sb_grant_id", grant_id, e.id);
                chk("sb_wren", bus_wren, !e.drop);
                chk("sb_err_page", err_page, e.drop);
                if (!e.drop) begin
                    chk("sb_addr", bus_addr, e.addr);
                    chk("sb_wdata", bus_wdata, e.data);
                    stamps.push_back(cyc);
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) begin
                if (hold_cnt[i] > 0) hold_cnt[i]--;
                else req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((sb.size() != 0 || busy || req != '0) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_pending"}, sb.size(), 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) hold_cnt[i] = 0;

        // Expected order follows the pointer carried from one vector to the next.
        vecs[0] = mk_vec(4'b1111, 4, 0, 1, 2, 3);
        vecs[1] = mk_vec(4'b0101, 2, 0, 2, 0, 0);
        vecs[2] = mk_vec(4'b0011, 2, 0, 1, 0, 0);
        vecs[3] = mk_vec(4'b1010, 2, 3, 1, 0, 0);
        vecs[4] = mk_vec(4'b0100, 1, 2, 0, 0, 0);
        vecs[5] = mk_vec(4'b1001, 2, 3, 0, 0, 0);

        repeat (3) step();
        chk("rst_wren", bus_wren, 0);
        chk("rst_ack", ack, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_wdata", bus_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err_page", err_page, 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < NVEC; v++) begin
            stamps.delete();
            for (int i = 0; i < NREQ; i++)
                if (vecs[v].mask[i]) set_req(i, mk_addr(i, v), mk_data(i, v));
            for (int k = 0; k < int'(vecs[v].n); k++)
                push(int'(vecs[v].order[k]), mk_addr(int'(vecs[v].order[k]), v),
                     mk_data(int'(vecs[v].order[k]), v), 1'b0);
            req = vecs[v].mask;
            wait_idle(100, "vec");
            chk("vec_count", stamps.size(), vecs[v].n);
            for (int k = 1; k < stamps.size(); k++)
                chk("vec_spacing", stamps[k] - stamps[k-1], 3 + GAP);
        end

        // Single request: setup cycle 1, strobe+ack cycle 2.
        set_req(0, 32'h0000_0400, 32'hA5A5_0001);
        push(0, 32'h0000_0400, 32'hA5A5_0001, 1'b0);
        req = 4'b0001;
        step();
        chk("single_c1_wren", bus_wren, 0);
        chk("single_c1_busy", busy, 1);
        chk("single_c1_addr", bus_addr, 32'h0000_0400);
        step();
        chk("single_c2_wren", bus_wren, 1);
        chk("single_c2_ack", ack, 4'b0001);
        chk("single_c2_addr", bus_addr, 32'h0000_0400);
        wait_idle(50, "single");

        // Fairness: requester 1 re-requests after its first ack, requester 2 pulses once.
        stamps.delete();
        hold_cnt[1] = 1;
        set_req(1, 32'h0000_0811, 32'h1111_0001);
        set_req(2, 32'h0000_0C22, 32'h2222_0002);
        push(1, 32'h0000_0811, 32'h1111_0001, 1'b0);
        push(2, 32'h0000_0C22, 32'h2222_0002, 1'b0);
        push(1, 32'h0000_0811, 32'h1111_0001, 1'b0);
        req = 4'b0110;
        wait_idle(100, "fair");
        chk("fair_count", stamps.size(), 3);

        // Requester 3 withdraws req and scrambles its inputs during SETUP.
        set_req(3, 32'h0000_0C33, 32'h3333_0003);
        push(3, 32'h0000_0C33, 32'h3333_0003, 1'b0);
        req = 4'b1000;
        step();
        chk("drop_setup_wren", bus_wren, 0);
        req[3] = 1'b0;
        set_req(3, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        step();
        chk("drop_strobe_wren", bus_wren, 1);
        chk("drop_strobe_ack", ack, 4'b1000);
        wait_idle(50, "drop");

        // Reset during STROBE clears strobe/ack at once; requester 0 then has priority again.
        set_req(0, 32'h0000_0044, 32'h4444_0004);
        push(0, 32'h0000_0044, 32'h4444_0004, 1'b0);
        req = 4'b0001;
        step();
        step();
        chk("rst_mid_pre_wren", bus_wren, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wren", bus_wren, 0);
        chk("rst_mid_ack", ack, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", bus_addr, 0);
        set_req(0, 32'h0000_0055, 32'h5555_0005);
        set_req(1, 32'h0000_0466, 32'h6666_0006);
        push(0, 32'h0000_0055, 32'h5555_0005, 1'b0);
        push(1, 32'h0000_0466, 32'h6666_0006, 1'b0);
        req = 4'b0011;
        step();
        step();
        chk("rst_hold_busy", busy, 0);
        rst_n = 1'b1;
        wait_idle(100, "post_rst");

        // Page 5 address.
        set_req(2, 32'h0000_1400, 32'h5A5A_0005);
`ifdef GP_WR_ARB_PAGE_CHECK_EN
        push(2, 32'h0000_1400, 32'h5A5A_0005, 1'b1);
        req = 4'b0100;
        step();
        chk("page_ack", ack, 4'b0100);
        chk("page_err", err_page, 1);
        chk("page_wren", bus_wren, 0);
        step();
        chk("page_after_wren", bus_wren, 0);
`else
        push(2, 32'h0000_1400, 32'h5A5A_0005, 1'b0);
        req = 4'b0100;
        step();
        chk("page_c1_wren", bus_wren, 0);
        step();
        chk("page_c2_wren", bus_wren, 1);
        chk("page_c2_ack", ack, 4'b0100);
        chk("page_c2_err", err_page, 0);
`endif
        wait_idle(50, "page");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gp_wr_arbiter.md
# gp_wr_arbiter

Round-robin arbiter and write sequencer sharing the single PS GP register-write bus between up to NREQ local requesters (PS bridge, laser sequencer, capture control, ...). It latches one winner's address/data, presents the address for a setup cycle, then issues a one-cycle write strobe. This satisfies the GP write decoder, which registers the page select one cycle before it samples wren. It sits directly in front of the GP write-strobe decoder and register file.

## Interface
- NREQ, 4, number of requesters (2..8)
- WTH_ADDR, 32, bus address width; low 10 bits are register offset, high 22 bits are page
- WTH_DATA, 32, write data width
- GAP, 1, idle cycles inserted after each strobe (0..7)
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NREQ  per-requester write request, level, held until ack
- req_addr  input  NREQ*WTH_ADDR  packed addresses, requester i at [i*WTH_ADDR +: WTH_ADDR]
- req_data  input  NREQ*WTH_DATA  packed write data, same packing
- ack  output  NREQ  one-cycle completion pulse to the granted requester
- bus_addr  output  WTH_ADDR  GP write address to decoder
- bus_wdata  output  WTH_DATA  GP write data
- bus_wren  output  1  GP write strobe, one cycle per transaction
- busy  output  1  high in any state other than IDLE
- grant_id  output  $clog2(NREQ)  index of current/last winner
- err_page  output  1  one-cycle pulse on dropped illegal-page write (only with GP_WR_ARB_PAGE_CHECK_EN)

## Operation
- FSM states: IDLE, SETUP, STROBE, GAP.
- IDLE: if any req bit is set, the round-robin pick starts at (last grant + 1) mod NREQ. Latch that requester's addr/data into bus_addr/bus_wdata, set grant_id, go to SETUP. If no req is set, stay in IDLE.
- SETUP: bus_addr is stable and bus_wren=0. Go to STROBE.
- STROBE: bus_wren=1 and ack[grant_id]=1 for exactly this cycle; bus_addr/bus_wdata unchanged. Go to GAP if GAP>0, else go to IDLE.
- GAP: count GAP cycles with a 3-bit counter, then go to IDLE. bus_addr/bus_wdata hold their last value.
- Data is latched at grant. A requester dropping req after grant does not cancel the write, and ack still pulses.
- A requester must deassert req in the cycle after ack. A req still high when the FSM re-enters IDLE is treated as a new request.
- Round-robin pointer updates only on grant. With a single requester continuously requesting, it receives back-to-back service.
- Out-of-range NREQ index never granted; unused req bits are ignored.

## Timing
- Reset (asynchronous, rst_n=0): state=IDLE, bus_wren=0, ack=0, bus_addr=0, bus_wdata=0, busy=0, grant_id=0, err_page=0, pointer set so requester 0 has first priority. All outputs are registered.
- Reset mid-transaction aborts it immediately: no ack, no strobe.
- Latency: req rises in cycle 0 with the FSM in IDLE → SETUP in cycle 1 → bus_wren=1 and ack in cycle 2.
- Throughput: one write per 3+GAP cycles.
- Simultaneous requests are served in round-robin order. No requester waits more than NREQ transactions.

## Configuration
- GP_WR_ARB_PAGE_CHECK_EN defined:
  - In IDLE, a winner whose address page exceeds 4 (OTHER) is dropped: no SETUP/STROBE, bus_wren stays 0.
  - The next cycle pulses ack[winner] and err_page together, then continues to GAP or IDLE.
  - The pointer still advances.
- GP_WR_ARB_PAGE_CHECK_EN not defined: every address is issued; err_page is tied to 0.

## Structure
- Shared package gp_bus_pkg holds:
  - WTH_ADDR, WTH_ADDL=10
  - page constants GLOBAL=0, CAPTURE=1, LASER=2, BUS=3, OTHER=4
  - the FSM state enum
- Sub-module gp_rr_arbiter: combinational round-robin pick (req, pointer → one-hot grant, index). Reusable for a future GP read arbiter.

## Test plan
- Single request: req[0]=1 with addr 0x0000_0400 (CAPTURE, offset 0) and data 0xA5A5_0001 → bus_wren high exactly in cycle 2, ack[0] in the same cycle, bus_addr stable in cycles 1-2.
- All four requesting at once, GAP=1 → strobes issued in order 0,1,2,3, spaced 4 cycles apart, each ack matching its grant_id.
- Fairness: req[1] held continuously while req[2] is pulsed → grants alternate 1,2,1.
- req[3] dropped in SETUP → strobe and ack[3] still occur with the latched data.
- rst_n asserted during STROBE → bus_wren and ack go to 0 at once. After release, requester 0 wins first.
- With GP_WR_ARB_PAGE_CHECK_EN, addr 0x0000_1400 (page 5) → no bus_wren, ack and err_page pulse one cycle after grant. Without the macro, the strobe is issued normally.
